// File: rtl/combo_lock_ctrl.sv
// Dial combination lock sequencer: Moore outputs decoded from the state register.
// Optional timed lockout after MAX_FAILS consecutive bad entries: define COMBO_LOCKOUT_EN.
module combo_lock_ctrl #(
  parameter int N_DIGITS    = 3,
  parameter int DIGIT_W     = 6,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                digit_vld,
  input  logic [DIGIT_W-1:0]                  digit_val,
  input  logic                                digit_cw,
  input  logic [N_DIGITS*DIGIT_W-1:0]         combo,
  input  logic                                lock_req,
  input  logic                                door_closed,
  output logic                                actuate_lock,
  output logic                                unlocked,
  output logic                                blank,
  output logic                                clr_count,
  output logic [$clog2(N_DIGITS)-1:0]         digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_cnt,
  output logic                                lockout
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  FAIL_MAX = FC_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTRY,
    S_OPEN,
    S_UNLOCKED,
    S_RELOCK,
    S_BAD,
    S_LOCKOUT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [FC_W-1:0]    r_fail, w_fail_nxt, w_fail_inc;
  logic [DIGIT_W-1:0] w_exp_digit;
  logic               w_match;

`ifdef COMBO_LOCKOUT_EN
  localparam int TMR_W = $clog2(LOCKOUT_CYC);
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
`endif

  // Even-numbered digits must be reached with a clockwise turn.
  assign w_exp_digit = combo[int'(r_idx)*DIGIT_W +: DIGIT_W];
  assign w_match     = (digit_val == w_exp_digit) && (digit_cw == ~r_idx[0]);
  assign w_fail_inc  = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

  assign digit_idx = (r_state == S_ENTRY) ? r_idx : '0;
  assign fail_cnt  = r_fail;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_fail_nxt   = r_fail;
`ifdef COMBO_LOCKOUT_EN
    w_tmr_nxt    = r_tmr;
`endif
    actuate_lock = 1'b0;
    unlocked     = 1'b0;
    blank        = 1'b0;
    clr_count    = 1'b1;
    lockout      = 1'b0;

    case (r_state)
      S_LOCKED: begin
        if (start) begin
          w_state_nxt = S_ENTRY;
          w_idx_nxt   = '0;
        end
      end
      S_ENTRY: begin
        blank     = 1'b1;
        clr_count = 1'b0;
        if (abort) begin
          w_state_nxt = S_LOCKED;
        end else if (digit_vld) begin
          if (!w_match)
            w_state_nxt = S_BAD;
          else if (r_idx == LAST_IDX)
            w_state_nxt = S_OPEN;
          else
            w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_OPEN: begin
        actuate_lock = 1'b1;
        blank        = 1'b1;
        w_fail_nxt   = '0;
        w_state_nxt  = S_UNLOCKED;
      end
      S_UNLOCKED: begin
        unlocked = 1'b1;
        if (lock_req && door_closed)
          w_state_nxt = S_RELOCK;
      end
      S_RELOCK: begin
        actuate_lock = 1'b1;
        w_state_nxt  = S_LOCKED;
      end
      S_BAD: begin
        blank      = 1'b1;
        w_fail_nxt = w_fail_inc;
`ifdef COMBO_LOCKOUT_EN
        if (w_fail_inc == FAIL_MAX) begin
          w_state_nxt = S_LOCKOUT;
          w_tmr_nxt   = TMR_W'(LOCKOUT_CYC - 1);
        end else begin
          w_state_nxt = S_LOCKED;
        end
`else
        w_state_nxt = S_LOCKED;
`endif
      end
`ifdef COMBO_LOCKOUT_EN
      S_LOCKOUT: begin
        blank   = 1'b1;
        lockout = 1'b1;
        if (r_tmr == '0) begin
          w_state_nxt = S_LOCKED;
          w_fail_nxt  = '0;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_LOCKED;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_fail <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_fail <= w_fail_nxt;
    end
  end

`ifdef COMBO_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tmr <= '0;
    else
      r_tmr <= w_tmr_nxt;
  end
`endif

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Randomized bench for combo_lock_ctrl against a phase-level behavioural model.
module tb_combo_lock_ctrl;
  localparam int N  = 3;
  localparam int W  = 6;
  localparam int MF = 3;
  localparam int LC = 10;
`ifdef COMBO_LOCKOUT_EN
  localparam bit LK_EN = 1'b1;
`else
  localparam bit LK_EN = 1'b0;
`endif

  localparam int P_LOCKED = 0, P_ENTRY = 1, P_OPEN = 2, P_UNLK = 3,
                 P_RELOCK = 4, P_BAD = 5, P_LOCKOUT = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0, abort = 1'b0, digit_vld = 1'b0, digit_cw = 1'b0;
  logic [W-1:0]   digit_val = '0;
  logic [N*W-1:0] combo = {6'd7, 6'd40, 6'd12};
  logic           lock_req = 1'b0, door_closed = 1'b0;
  logic           actuate_lock, unlocked, blank, clr_count, lockout;
  logic [1:0]     digit_idx;
  logic [1:0]     fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int digits [N] = '{12, 40, 7};
  bit blank_tab [7] = '{0, 1, 1, 0, 0, 1, 1};
  int m_ph = P_LOCKED, m_pos = 0, m_fails = 0, m_left = 0;

  combo_lock_ctrl #(.N_DIGITS(N), .DIGIT_W(W), .MAX_FAILS(MF), .LOCKOUT_CYC(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .digit_vld(digit_vld), .digit_val(digit_val), .digit_cw(digit_cw),
    .combo(combo), .lock_req(lock_req), .door_closed(door_closed),
    .actuate_lock(actuate_lock), .unlocked(unlocked), .blank(blank),
    .clr_count(clr_count), .digit_idx(digit_idx), .fail_cnt(fail_cnt),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk_eq("actuate_lock", actuate_lock, (m_ph == P_OPEN) || (m_ph == P_RELOCK));
    chk_eq("unlocked", unlocked, m_ph == P_UNLK);
    chk_eq("blank", blank, blank_tab[m_ph]);
    chk_eq("clr_count", clr_count, m_ph != P_ENTRY);
    chk_eq("digit_idx", digit_idx, (m_ph == P_ENTRY) ? m_pos : 0);
    chk_eq("fail_cnt", fail_cnt, m_fails);
    chk_eq("lockout", lockout, m_ph == P_LOCKOUT);
  endtask

  task automatic model_step(input bit st, input bit ab, input bit dv, input int dval,
                            input bit cw, input bit lr, input bit dc);
    case (m_ph)
      P_LOCKED: if (st) begin m_ph = P_ENTRY; m_pos = 0; end
      P_ENTRY: begin
        if (ab) m_ph = P_LOCKED;
        else if (dv) begin
          if (dval == digits[m_pos] && cw == (m_pos % 2 == 0)) begin
            if (m_pos == N - 1) m_ph = P_OPEN;
            else m_pos++;
          end else m_ph = P_BAD;
        end
      end
      P_OPEN: begin m_fails = 0; m_ph = P_UNLK; end
      P_UNLK: if (lr && dc) m_ph = P_RELOCK;
      P_RELOCK: m_ph = P_LOCKED;
      P_BAD: begin
        if (m_fails < MF) m_fails++;
        if (LK_EN && m_fails == MF) begin m_ph = P_LOCKOUT; m_left = LC; end
        else m_ph = P_LOCKED;
      end
      P_LOCKOUT: begin
        m_left--;
        if (m_left == 0) begin m_ph = P_LOCKED; m_fails = 0; end
      end
      default: m_ph = P_LOCKED;
    endcase
  endtask

  // Checks the current outputs, drives one cycle of inputs, advances the model.
  task automatic tick(input bit st, input bit ab, input bit dv, input int dval,
                      input bit cw, input bit lr, input bit dc);
    @(negedge clk);
    check_outputs();
    start = st; abort = ab; digit_vld = dv; digit_val = W'(dval);
    digit_cw = cw; lock_req = lr; door_closed = dc;
    @(posedge clk);
    model_step(st, ab, dv, dval, cw, lr, dc);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_ph = P_LOCKED; m_pos = 0; m_fails = 0; m_left = 0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bad_entry();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 0, 1, 41, 0, 0, 0);
    idle();
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #2 check_outputs();
    chk_eq("rst_clr_count", clr_count, 1);
    @(negedge clk);
    rst = 1'b0;

    // Correct entry, then relock with the door open and closed.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 0, 1, 40, 0, 0, 0);
    tick(0, 0, 1, 7, 1, 0, 0);
    #1 chk_eq("open_pulse", actuate_lock, 1);
    idle();
    #1 chk_eq("open_unlocked", unlocked, 1);
    chk_eq("open_pulse_end", actuate_lock, 0);
    chk_eq("open_fail", fail_cnt, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    #1 chk_eq("relock_door_open", unlocked, 1);
    tick(0, 0, 0, 0, 0, 1, 1);
    #1 chk_eq("relock_pulse", actuate_lock, 1);
    idle();
    #1 chk_eq("relock_done", unlocked | actuate_lock, 0);

    // Wrong value, then right value with the wrong direction.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 0, 1, 41, 0, 0, 0);
    #1 chk_eq("bad_blank", blank, 1);
    idle();
    #1 chk_eq("bad_fail1", fail_cnt, 1);
    chk_eq("bad_blank_after", blank, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 0, 1, 40, 1, 0, 0);
    idle();
    #1 chk_eq("bad_dir_fail2", fail_cnt, 2);

    // Third bad entry: lockout length and ignored inputs.
    bad_entry();
    #1;
    cnt = 0;
    while (lockout === 1'b1 && cnt < 40) begin
      cnt++;
      tick(1, 0, 1, 5, 1, 1, 1);
      #1;
    end
    chk_eq("lockout_len", cnt, LK_EN ? LC : 0);
    chk_eq("lockout_fail_after", fail_cnt, LK_EN ? 0 : MF);
    chk_eq("lockout_then_locked", clr_count & ~blank, 1);

    // Reset mid-entry, then abort racing a digit strobe.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 0, 1, 40, 0, 0, 0);
    do_reset();
    chk_eq("rst_mid_fail", fail_cnt, 0);
    bad_entry();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 12, 1, 0, 0);
    tick(0, 1, 1, 40, 0, 0, 0);
    #1 chk_eq("abort_idx", digit_idx, 0);
    chk_eq("abort_fail", fail_cnt, 1);
    chk_eq("abort_locked", blank, 0);

    for (int i = 0; i < 3000; i++) begin
      bit st, ab, dv, cw, lr, dc;
      int dval;
      if ($urandom_range(0, 299) == 0) do_reset();
      st = ($urandom_range(0, 9) < 3);
      ab = ($urandom_range(0, 39) == 0);
      dv = ($urandom_range(0, 9) < 4);
      if (m_ph == P_ENTRY && $urandom_range(0, 9) < 7) begin
        dval = digits[m_pos];
        cw = (m_pos % 2 == 0) ^ ($urandom_range(0, 9) < 2);
      end else begin
        dval = int'($urandom_range(0, 63));
        cw = $urandom_range(0, 1) == 1;
      end
      lr = ($urandom_range(0, 9) < 2);
      dc = $urandom_range(0, 1) == 1;
      tick(st, ab, dv, dval, cw, lr, dc);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
